// File: rtl/fred_pkg.sv
// Shared types and catalogue defaults for the checkout lane.
// The default masks mark UPCs 4,5,6 as discounted and UPCs 1,2,6,7 as expensive.
package fred_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ALARM  = 2'd2,
    DONE   = 2'd3
  } lane_state_t;

  localparam int          UPC_W_DEF          = 3;
  localparam int          CNT_W_DEF          = 4;
  localparam int          MAX_ITEMS_DEF      = 15;
  localparam logic [7:0]  DISCOUNT_MASK_DEF  = 8'h70;
  localparam logic [7:0]  EXPENSIVE_MASK_DEF = 8'hC6;

endpackage

// File: rtl/fred_checkout_lane_if.sv
// Key/switch inputs and count/flag outputs of one checkout lane.
// The master side drives keys and the item code; the slave side is the lane itself.
interface fred_checkout_lane_if
  import fred_pkg::*;
#(
  parameter int UPC_W = UPC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [UPC_W-1:0] upc;
  logic             marked;
  logic             scan_key;
  logic             total_key;
  logic             clear_key;
  logic [CNT_W-1:0] item_count;
  logic [CNT_W-1:0] discount_count;
  logic [UPC_W-1:0] last_upc;
  logic             last_valid;
  logic             last_discount;
  logic             alarm;
  logic             done;

  modport master (
    output upc, marked, scan_key, total_key, clear_key,
    input  item_count, discount_count, last_upc, last_valid,
           last_discount, alarm, done
  );

  modport slave (
    input  upc, marked, scan_key, total_key, clear_key,
    output item_count, discount_count, last_upc, last_valid,
           last_discount, alarm, done
  );

endinterface

// File: rtl/fred_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a key is first seen high.
// A key already high when reset is released must be seen low once before it can pulse.
module fred_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev_reg;
  logic armed_reg;
  logic pulse_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg  <= 1'b0;
      armed_reg <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      prev_reg  <= in;
      pulse_reg <= in & ~prev_reg & armed_reg;
      if (!in) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/fred_checkout_lane.sv
// Checkout lane: edge-detected keys drive an IDLE/ACTIVE/ALARM/DONE FSM that counts
// accepted items and discounts, raises a sticky theft alarm and freezes totals on close.
module fred_checkout_lane
  import fred_pkg::*;
#(
  parameter int                   UPC_W          = UPC_W_DEF,
  parameter int                   CNT_W          = CNT_W_DEF,
  parameter int                   MAX_ITEMS      = MAX_ITEMS_DEF,
  parameter logic [2**UPC_W-1:0]  DISCOUNT_MASK  = DISCOUNT_MASK_DEF,
  parameter logic [2**UPC_W-1:0]  EXPENSIVE_MASK = EXPENSIVE_MASK_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  fred_checkout_lane_if.slave  lane
);

  // Bit order: 0 = scan, 1 = total, 2 = clear
  logic [2:0] key_level;
  logic [2:0] key_pulse;

  assign key_level = {lane.clear_key, lane.total_key, lane.scan_key};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      fred_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .in    (key_level[gi]),
        .pulse (key_pulse[gi])
      );
    end
  endgenerate

  lane_state_t      state_reg, state_next;
  logic [CNT_W-1:0] item_reg, item_next;
  logic [CNT_W-1:0] disc_reg, disc_next;
  logic [UPC_W-1:0] last_upc_reg, last_upc_next;
  logic             last_valid_reg, last_valid_next;
  logic             last_disc_reg, last_disc_next;
  logic             alarm_reg, alarm_next;
  logic             done_reg, done_next;

  logic is_discount;
  logic is_theft;
  logic sale_open;

  assign is_discount = DISCOUNT_MASK[lane.upc];
  assign is_theft    = EXPENSIVE_MASK[lane.upc] & ~lane.marked;
  assign sale_open   = (state_reg == IDLE) || (state_reg == ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      item_reg       <= '0;
      disc_reg       <= '0;
      last_upc_reg   <= '0;
      last_valid_reg <= 1'b0;
      last_disc_reg  <= 1'b0;
      alarm_reg      <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      item_reg       <= item_next;
      disc_reg       <= disc_next;
      last_upc_reg   <= last_upc_next;
      last_valid_reg <= last_valid_next;
      last_disc_reg  <= last_disc_next;
      alarm_reg      <= alarm_next;
      done_reg       <= done_next;
    end
  end

  // Priority clear > total > scan; lower-priority pulses in the same cycle are dropped.
  always_comb begin
    state_next      = state_reg;
    item_next       = item_reg;
    disc_next       = disc_reg;
    last_upc_next   = last_upc_reg;
    last_valid_next = last_valid_reg;
    last_disc_next  = last_disc_reg;
    alarm_next      = alarm_reg;
    done_next       = done_reg;

    if (key_pulse[2]) begin
      state_next      = IDLE;
      item_next       = '0;
      disc_next       = '0;
      last_upc_next   = '0;
      last_valid_next = 1'b0;
      last_disc_next  = 1'b0;
      alarm_next      = 1'b0;
      done_next       = 1'b0;
    end else if (key_pulse[1]) begin
      if (sale_open) begin
        state_next = DONE;
        done_next  = 1'b1;
      end
    end else if (key_pulse[0] && sale_open) begin
      // Theft is checked before saturation so a full basket still trips the alarm.
      if (is_theft) begin
        state_next = ALARM;
        alarm_next = 1'b1;
      end else if (item_reg != CNT_W'(MAX_ITEMS)) begin
        item_next       = item_reg + CNT_W'(1);
        disc_next       = is_discount ? disc_reg + CNT_W'(1) : disc_reg;
        last_upc_next   = lane.upc;
        last_valid_next = 1'b1;
        last_disc_next  = is_discount;
        state_next      = ACTIVE;
      end
    end
  end

  assign lane.item_count     = item_reg;
  assign lane.discount_count = disc_reg;
  assign lane.last_upc       = last_upc_reg;
  assign lane.last_valid     = last_valid_reg;
  assign lane.last_discount  = last_disc_reg;
  assign lane.alarm          = alarm_reg;
  assign lane.done           = done_reg;

endmodule

// File: tb/tb_fred_checkout_lane.sv
// Self-checking bench for fred_checkout_lane: directed table, corner sequences and
// randomized key presses against a behavioural model of the lane rules.
module tb_fred_checkout_lane;

  localparam logic [2:0] K_S = 3'b001;
  localparam logic [2:0] K_T = 3'b010;
  localparam logic [2:0] K_C = 3'b100;

  logic clk = 1'b0;
  logic reset;

  fred_checkout_lane_if lane_if ();

  fred_checkout_lane dut (
    .clk   (clk),
    .reset (reset),
    .lane  (lane_if)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0] keys;
    logic [2:0] upc;
    logic       marked;
    int ic; int dc; int lu; int lv; int ld; int al; int dn;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  logic [7:0] disc_mask = 8'h70;
  logic [7:0] exp_mask  = 8'hC6;
  int m_ic, m_dc, m_lu, m_lv, m_ld, m_al, m_dn;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input int ic, input int dc, input int lu,
                           input int lv, input int ld, input int al, input int dn);
    chk({tag, ".item_count"},     int'(lane_if.item_count),     ic);
    chk({tag, ".discount_count"}, int'(lane_if.discount_count), dc);
    chk({tag, ".last_upc"},       int'(lane_if.last_upc),       lu);
    chk({tag, ".last_valid"},     int'(lane_if.last_valid),     lv);
    chk({tag, ".last_discount"},  int'(lane_if.last_discount),  ld);
    chk({tag, ".alarm"},          int'(lane_if.alarm),          al);
    chk({tag, ".done"},           int'(lane_if.done),           dn);
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_ic, m_dc, m_lu, m_lv, m_ld, m_al, m_dn);
  endtask

  // Press keys together, wait until the lane has acted, then release and let the detectors see low.
  task automatic press(input logic [2:0] keys, input logic [2:0] upc, input logic marked);
    @(negedge clk);
    lane_if.upc       = upc;
    lane_if.marked    = marked;
    lane_if.scan_key  = keys[0];
    lane_if.total_key = keys[1];
    lane_if.clear_key = keys[2];
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("txn keys(c,t,s)=%b upc=%0d marked=%0b -> items=%0d disc=%0d last=%0d/%0b/%0b alarm=%0b done=%0b",
             keys, upc, marked, lane_if.item_count, lane_if.discount_count, lane_if.last_upc,
             lane_if.last_valid, lane_if.last_discount, lane_if.alarm, lane_if.done);
  endtask

  task automatic release_keys();
    @(negedge clk);
    lane_if.scan_key  = 1'b0;
    lane_if.total_key = 1'b0;
    lane_if.clear_key = 1'b0;
    @(posedge clk);
  endtask

  task automatic model_clear();
    m_ic = 0; m_dc = 0; m_lu = 0; m_lv = 0; m_ld = 0; m_al = 0; m_dn = 0;
  endtask

  task automatic model_step(input logic [2:0] keys, input logic [2:0] upc, input logic marked);
    bit open;
    open = (m_al == 0) && (m_dn == 0);
    if (keys[2]) begin
      model_clear();
    end else if (keys[1]) begin
      if (open) m_dn = 1;
    end else if (keys[0] && open) begin
      if (exp_mask[upc] && !marked) begin
        m_al = 1;
      end else if (m_ic < 15) begin
        m_ic++;
        if (disc_mask[upc]) m_dc++;
        m_lu = int'(upc);
        m_lv = 1;
        m_ld = disc_mask[upc] ? 1 : 0;
      end
    end
  endtask

  initial begin
    lane_if.upc       = '0;
    lane_if.marked    = 1'b0;
    lane_if.scan_key  = 1'b0;
    lane_if.total_key = 1'b0;
    lane_if.clear_key = 1'b0;
    reset = 1'b1;

    //            keys upc mk  ic dc lu lv ld al dn
    tbl.push_back('{K_S, 3'd0, 1'b0, 1, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{K_C, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_S, 3'd6, 1'b1, 1, 1, 6, 1, 1, 0, 0});
    tbl.push_back('{K_S, 3'd5, 1'b0, 2, 2, 5, 1, 1, 0, 0});
    tbl.push_back('{K_T, 3'd0, 1'b0, 2, 2, 5, 1, 1, 0, 1});
    tbl.push_back('{K_S, 3'd3, 1'b0, 2, 2, 5, 1, 1, 0, 1});
    tbl.push_back('{K_T, 3'd0, 1'b0, 2, 2, 5, 1, 1, 0, 1});
    tbl.push_back('{K_C, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_S, 3'd3, 1'b1, 1, 0, 3, 1, 0, 0, 0});
    tbl.push_back('{K_S, 3'd7, 1'b0, 1, 0, 3, 1, 0, 1, 0});
    tbl.push_back('{K_S, 3'd0, 1'b0, 1, 0, 3, 1, 0, 1, 0});
    tbl.push_back('{K_T, 3'd0, 1'b0, 1, 0, 3, 1, 0, 1, 0});
    tbl.push_back('{K_C, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_T, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{K_S, 3'd1, 1'b0, 0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{K_C, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_S, 3'd1, 1'b0, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{K_C, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{K_S, 3'd2, 1'b1, 1, 0, 2, 1, 0, 0, 0});
    tbl.push_back('{K_C, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, 0});

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      press(tbl[i].keys, tbl[i].upc, tbl[i].marked);
      check_all($sformatf("tbl%0d", i), tbl[i].ic, tbl[i].dc, tbl[i].lu,
                tbl[i].lv, tbl[i].ld, tbl[i].al, tbl[i].dn);
      release_keys();
    end

    // Saturation: 16 discounted items, then a non-theft scan is ignored, theft still alarms
    for (int k = 1; k <= 16; k++) begin
      press(K_S, 3'd4, 1'b0);
      chk($sformatf("sat%0d.item_count", k), int'(lane_if.item_count), (k > 15) ? 15 : k);
      chk($sformatf("sat%0d.discount_count", k), int'(lane_if.discount_count), (k > 15) ? 15 : k);
      release_keys();
    end
    press(K_S, 3'd0, 1'b0);
    check_all("sat_ignore", 15, 15, 4, 1, 1, 0, 0);
    release_keys();
    press(K_S, 3'd2, 1'b0);
    check_all("sat_theft", 15, 15, 4, 1, 1, 1, 0);
    release_keys();
    press(K_C, 3'd0, 1'b0);
    release_keys();

    // Scan and clear in the same cycle: clear wins
    press(K_S, 3'd3, 1'b0);
    release_keys();
    press(K_S | K_C, 3'd5, 1'b0);
    check_all("scan_clear", 0, 0, 0, 0, 0, 0, 0);
    release_keys();

    // Scan key held 20 cycles counts once
    @(negedge clk);
    lane_if.upc      = 3'd5;
    lane_if.marked   = 1'b0;
    lane_if.scan_key = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_all("held20", 1, 1, 5, 1, 1, 0, 0);
    release_keys();

    // Key held through reset yields no pulse
    @(negedge clk);
    lane_if.upc      = 3'd0;
    lane_if.scan_key = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_all("held_reset", 0, 0, 0, 0, 0, 0, 0);
    release_keys();
    press(K_S, 3'd0, 1'b0);
    chk("after_reset.item_count", int'(lane_if.item_count), 1);
    release_keys();

    // Asynchronous reset mid-sale
    press(K_S, 3'd4, 1'b0);
    release_keys();
    press(K_S, 3'd5, 1'b0);
    release_keys();
    chk("pre_async.item_count", int'(lane_if.item_count), 3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized presses against the model
    model_clear();
    for (int n = 0; n < 300; n++) begin
      logic [2:0] keys;
      logic [2:0] upc;
      logic       mk;
      keys[0] = ($urandom % 100) < 85;
      keys[1] = ($urandom % 100) < 6;
      keys[2] = ($urandom % 100) < 4;
      if (keys == 3'b000) keys[0] = 1'b1;
      upc = 3'($urandom_range(0, 7));
      mk  = ($urandom % 100) < 85;
      model_step(keys, upc, mk);
      press(keys, upc, mk);
      check_model($sformatf("rnd%0d", n));
      release_keys();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
